// File: rtl/north_bus_arbiter_pkg.sv
// north_arb_pkg: shared types and constants for the north memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE=0, ISSUE=1, WAIT=2)
//   TO_CNT_W    : width of the per-beat wait counter (timeout build only)
//   RW_READ / RW_WRITE : encoding of the per-master req_wr bit
package north_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int   TO_CNT_W = 8;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/north_bus_arbiter_if.sv
// north_bus_arbiter_if: bundle of requester-side and north-memory-side signals.
//   master modport : requesters plus north memory model (drive req*, data_north, mem_rdy)
//   slave modport  : the arbiter (drives gnt/done/err/rdata and the north port)
interface north_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         write_data;
    logic                      mem_read_north;
    logic                      mem_write_north;
    logic [DATA_W-1:0]         data_north;
    logic                      mem_rdy;

    modport master (
        output req, req_lock, req_wr, req_addr, req_wdata, data_north, mem_rdy,
        input  gnt, done, err, rdata, addr, write_data, mem_read_north, mem_write_north
    );

    modport slave (
        input  req, req_lock, req_wr, req_addr, req_wdata, data_north, mem_rdy,
        output gnt, done, err, rdata, addr, write_data, mem_read_north, mem_write_north
    );
endinterface

// File: rtl/north_bus_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick.
//   req  in  NUM_REQ : pending requests
//   ptr  in  IDX_W   : index of the last served master
//   pick out NUM_REQ : one-hot first requester after ptr (wrapping), or zero
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick
);

    // Scan offsets 1..NUM_REQ from the pointer; the first set request wins.
    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end else begin
                    found   = found;
                end
            end
        end
    end

endmodule

// File: rtl/north_bus_arbiter.sv
// north_bus_arbiter: round-robin arbiter sharing the 16-bit north memory port
// between NUM_REQ masters (0 = data mem interface, 1 = fetch/DMA).
//   clk, rst : clock and asynchronous active-high reset
//   bus      : north_bus_arbiter_if.slave (requests in; gnt/done/err/rdata out;
//              addr/write_data/mem_read_north/mem_write_north out; data_north/mem_rdy in)
// Optional feature macro: NORTH_ARB_TIMEOUT_EN adds a per-beat wait counter that
// aborts a beat with err=1 after TIMEOUT_CYC WAIT cycles without mem_rdy.
module north_bus_arbiter
    import north_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16
`ifdef NORTH_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic               clk,
    input  logic               rst,
    north_bus_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
`ifdef NORTH_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);
    logic                err_q, err_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [NUM_REQ-1:0]  pick_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [ADDR_W-1:0]   pick_addr_s;
    logic [DATA_W-1:0]   pick_wdata_s;
    logic [ADDR_W-1:0]   own_addr_s;
    logic [DATA_W-1:0]   own_wdata_s;
    logic                own_wr_s;
    logic                own_req_s;
    logic                own_lock_s;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick_s)
    );

    // Select the fields of the freshly picked master and of the current owner.
    always_comb begin
        pick_idx_s   = '0;
        pick_addr_s  = '0;
        pick_wdata_s = '0;
        own_addr_s   = '0;
        own_wdata_s  = '0;
        own_wr_s     = 1'b0;
        own_req_s    = 1'b0;
        own_lock_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_s[i]) begin
                pick_idx_s   = IDX_W'(i);
                pick_addr_s  = bus.req_addr[i*ADDR_W +: ADDR_W];
                pick_wdata_s = bus.req_wdata[i*DATA_W +: DATA_W];
            end else begin
                pick_idx_s   = pick_idx_s;
            end
            if (owner_q == IDX_W'(i)) begin
                own_addr_s  = bus.req_addr[i*ADDR_W +: ADDR_W];
                own_wdata_s = bus.req_wdata[i*DATA_W +: DATA_W];
                own_wr_s    = bus.req_wr[i];
                own_req_s   = bus.req[i];
                own_lock_s  = bus.req_lock[i];
            end else begin
                own_wr_s    = own_wr_s;
            end
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT beat sequence.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
`ifdef NORTH_ARB_TIMEOUT_EN
        err_d   = 1'b0;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_d   = pick_s;
                    owner_d = pick_idx_s;
                    addr_d  = pick_addr_s;
                    wdata_d = pick_wdata_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Re-latching here also picks up the next beat of a locked chain,
                // which the owner presents only after seeing its done pulse.
                addr_d  = own_addr_s;
                wdata_d = own_wdata_s;
                rd_d    = (own_wr_s == RW_READ);
                wr_d    = (own_wr_s == RW_WRITE);
`ifdef NORTH_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_rdy) begin
                    rd_d   = 1'b0;
                    wr_d   = 1'b0;
                    done_d = gnt_q;
                    ptr_d  = owner_q;
                    if (rd_q) begin
                        rdata_d = bus.data_north;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    // A lock with the request already dropped counts as unlocked.
                    if (own_lock_s && own_req_s) begin
                        state_d = ST_ISSUE;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
`ifdef NORTH_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    ptr_d   = owner_q;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            default: begin
                gnt_d   = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops strobes and grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
`ifdef NORTH_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
`ifdef NORTH_ARB_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.done            = done_q;
    assign bus.rdata           = rdata_q;
    assign bus.addr            = addr_q;
    assign bus.write_data      = wdata_q;
    assign bus.mem_read_north  = rd_q;
    assign bus.mem_write_north = wr_q;
`ifdef NORTH_ARB_TIMEOUT_EN
    assign bus.err             = err_q;
`else
    assign bus.err             = 1'b0;
`endif

endmodule

// File: tb/tb_north_bus_arbiter.sv
// Testbench for north_bus_arbiter: table of single-beat vectors plus directed
// sequences for locking, idle mem_rdy, reset mid-beat and (NORTH_ARB_TIMEOUT_EN) timeout.
module tb_north_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    north_bus_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(16)) bus ();

    north_bus_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (32),
        .DATA_W  (16)
`ifdef NORTH_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (4)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [15:0] wd0;
        logic [15:0] wd1;
        int          delay;
        logic [15:0] dn;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_addr;
        logic [15:0] exp_wd;
        logic [1:0]  exp_strobe;   // {read, write}
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] strobes();
        return {bus.mem_read_north, bus.mem_write_north};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          req    wr     addr0          addr1          wd0       wd1       dly dn        gnt    addr           wd        {r,w}  rdata
        vecs[0] = '{2'b11, 2'b00, 32'h0000_0020, 32'h0000_0024, 16'hAAAA, 16'hBBBB, 0, 16'h1111, 2'b01, 32'h0000_0020, 16'hAAAA, 2'b10, 16'h1111};
        vecs[1] = '{2'b11, 2'b10, 32'h0000_0020, 32'h0000_0030, 16'hAAAA, 16'hA5A5, 1, 16'h9999, 2'b10, 32'h0000_0030, 16'hA5A5, 2'b01, 16'h1111};
        vecs[2] = '{2'b11, 2'b01, 32'h0000_0040, 32'h0000_0044, 16'h0F0F, 16'hF0F0, 2, 16'h8888, 2'b01, 32'h0000_0040, 16'h0F0F, 2'b01, 16'h1111};
        vecs[3] = '{2'b01, 2'b00, 32'h0000_0010, 32'h0000_0000, 16'h0000, 16'h0000, 3, 16'hBEEF, 2'b01, 32'h0000_0010, 16'h0000, 2'b10, 16'hBEEF};
        vecs[4] = '{2'b10, 2'b00, 32'h0000_0000, 32'hFFFF_FFFC, 16'h0000, 16'h0001, 0, 16'h0000, 2'b10, 32'hFFFF_FFFC, 16'h0001, 2'b10, 16'h0000};
        vecs[5] = '{2'b01, 2'b11, 32'h8000_0000, 32'h0000_0000, 16'hFFFF, 16'h0000, 1, 16'h2222, 2'b01, 32'h8000_0000, 16'hFFFF, 2'b01, 16'h0000};

        rst           = 1'b1;
        bus.req       = '0;
        bus.req_lock  = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.data_north = '0;
        bus.mem_rdy   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_gnt",   32'(bus.gnt), 32'h0);
        check("reset_done",  32'(bus.done), 32'h0);
        check("reset_err",   32'(bus.err), 32'h0);
        check("reset_strb",  32'(strobes()), 32'h0);
        check("reset_addr",  bus.addr, 32'h0);
        check("reset_wdata", 32'(bus.write_data), 32'h0);
        check("reset_rdata", 32'(bus.rdata), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single beats; rr pointer evolves across rows.
        for (int i = 0; i < 6; i++) begin
            bus.req       = vecs[i].req;
            bus.req_wr    = vecs[i].wr;
            bus.req_lock  = 2'b00;
            bus.req_addr  = {vecs[i].addr1, vecs[i].addr0};
            bus.req_wdata = {vecs[i].wd1, vecs[i].wd0};
            bus.mem_rdy   = 1'b0;
            bus.data_north = vecs[i].dn;
            @(negedge clk);
            check("issue_done_low", 32'(bus.done), 32'h0);
            check("issue_gnt",      32'(bus.gnt), 32'(vecs[i].exp_gnt));
            check("issue_addr",     bus.addr, vecs[i].exp_addr);
            check("issue_wdata",    32'(bus.write_data), 32'(vecs[i].exp_wd));
            check("issue_no_strb",  32'(strobes()), 32'h0);
            @(negedge clk);
            check("wait_strobe",    32'(strobes()), 32'(vecs[i].exp_strobe));
            for (int d = 0; d < vecs[i].delay; d++) begin
                @(negedge clk);
                check("wait_held",  32'({strobes(), bus.done}), 32'({vecs[i].exp_strobe, 2'b00}));
            end
            bus.mem_rdy = 1'b1;
            @(negedge clk);
            check("done_pulse",     32'(bus.done), 32'(vecs[i].exp_gnt));
            check("done_err",       32'(bus.err), 32'h0);
            check("done_rdata",     32'(bus.rdata), 32'(vecs[i].exp_rdata));
            check("done_strb_off",  32'(strobes()), 32'h0);
            check("done_gnt_off",   32'(bus.gnt), 32'h0);
            bus.mem_rdy = 1'b0;
            bus.req     = 2'b00;
        end

        // Locked 32-bit write by master 1 while master 0 waits.
        bus.req       = 2'b11;
        bus.req_lock  = 2'b10;
        bus.req_wr    = 2'b10;
        bus.req_addr  = {32'h0000_0100, 32'h0000_0200};
        bus.req_wdata = {16'h5678, 16'h0000};
        bus.data_north = 16'h3333;
        @(negedge clk);
        check("lock_gnt1",   32'(bus.gnt), 32'h2);
        check("lock_addr1",  bus.addr, 32'h0000_0100);
        check("lock_wd1",    32'(bus.write_data), 32'h5678);
        @(negedge clk);
        check("lock_wr1",    32'(strobes()), 32'h1);
        bus.mem_rdy = 1'b1;
        @(negedge clk);
        check("lock_done1",  32'(bus.done), 32'h2);
        check("lock_gnt_hold", 32'(bus.gnt), 32'h2);
        check("lock_strb_off", 32'(strobes()), 32'h0);
        bus.mem_rdy   = 1'b0;
        bus.req_lock  = 2'b00;
        bus.req_addr  = {32'h0000_0101, 32'h0000_0200};
        bus.req_wdata = {16'h1234, 16'h0000};
        @(negedge clk);
        check("lock_gnt2",   32'(bus.gnt), 32'h2);
        check("lock_addr2",  bus.addr, 32'h0000_0101);
        check("lock_wd2",    32'(bus.write_data), 32'h1234);
        check("lock_wr2",    32'(strobes()), 32'h1);
        bus.mem_rdy = 1'b1;
        @(negedge clk);
        check("lock_done2",  32'(bus.done), 32'h2);
        check("lock_gnt_rel", 32'(bus.gnt), 32'h0);
        bus.mem_rdy = 1'b0;
        bus.req     = 2'b01;
        @(negedge clk);
        check("after_lock_gnt0",  32'(bus.gnt), 32'h1);
        check("after_lock_addr0", bus.addr, 32'h0000_0200);
        @(negedge clk);
        check("after_lock_rd",    32'(strobes()), 32'h2);
        bus.mem_rdy = 1'b1;
        @(negedge clk);
        check("after_lock_done",  32'(bus.done), 32'h1);
        check("after_lock_rdata", 32'(bus.rdata), 32'h3333);
        bus.mem_rdy = 1'b0;
        bus.req     = 2'b00;

        // mem_rdy while idle with no request must be ignored.
        bus.mem_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_rdy", 32'({strobes(), bus.done, bus.gnt}), 32'h0);
        end
        bus.mem_rdy = 1'b0;

        // Reset in the middle of a write beat.
        bus.req       = 2'b01;
        bus.req_wr    = 2'b01;
        bus.req_addr  = {32'h0000_0000, 32'h0000_0055};
        bus.req_wdata = {16'h0000, 16'h7777};
        @(negedge clk);
        @(negedge clk);
        check("rstmid_wr_before", 32'(strobes()), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_strb_drop", 32'(strobes()), 32'h0);
        check("rstmid_gnt_drop",  32'(bus.gnt), 32'h0);
        @(negedge clk);
        check("rstmid_no_done",   32'(bus.done), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_regrant",   32'(bus.gnt), 32'h1);
        check("rstmid_addr",      bus.addr, 32'h0000_0055);
        @(negedge clk);
        check("rstmid_wr_again",  32'(strobes()), 32'h1);
        bus.mem_rdy = 1'b1;
        @(negedge clk);
        check("rstmid_done",      32'(bus.done), 32'h1);
        check("rstmid_rdata",     32'(bus.rdata), 32'h0);
        bus.mem_rdy = 1'b0;
        bus.req     = 2'b00;

`ifdef NORTH_ARB_TIMEOUT_EN
        // Beat abandoned after four WAIT cycles without mem_rdy.
        bus.req        = 2'b01;
        bus.req_wr     = 2'b00;
        bus.data_north = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        check("to_rd", 32'(strobes()), 32'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("to_wait", 32'({strobes(), bus.done}), 32'({2'b10, 2'b00}));
        end
        @(negedge clk);
        check("to_done",  32'(bus.done), 32'h1);
        check("to_err",   32'(bus.err), 32'h1);
        check("to_strb",  32'(strobes()), 32'h0);
        check("to_rdata", 32'(bus.rdata), 32'h0);
        bus.req = 2'b00;
        @(negedge clk);
        check("to_idle", 32'({strobes(), bus.gnt, bus.err}), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
